id_ex_ctrl_stage: RTL

//  ID/EX pipeline stage for the control path, downstream of the opcode decoder.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/hazard_detect.sv | 18 +
 rtl/id_ex_ctrl_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU-op and opcode constants, control bundle type.
package cpu_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int CTRL_W         = 10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_R_TYPE = 2'b10;
  localparam logic [1:0] ALU_JUMP   = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the instruction in EX is a load whose rd feeds ID.
module hazard_detect import cpu_pkg::*; #(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  lu
);

  // x0 is hardwired zero, so a load into it never creates a dependency
  assign lu = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
              ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control-path pipeline register with load-use bubbling, flush and hold.
// HAZARD_STATS_EN adds stall_cnt/flush_cnt statistics counters.
module id_ex_ctrl_stage import cpu_pkg::*; #(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_reg_dst,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_2_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_jump,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  ex_valid,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_reg_dst,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_2_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_jump,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  pc_write,
  output logic                  if_id_write
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0]    stall_cnt
  , output logic [CNT_W-1:0]    flush_cnt
`endif
);

  ctrl_t id_ctrl, ex_ctrl;
  logic  lu;
  logic  load_id;

  assign id_ctrl = '{alu_op:    id_alu_op,
                     reg_dst:   id_reg_dst,
                     branch:    id_branch,
                     mem_read:  id_mem_read,
                     mem_2_reg: id_mem_2_reg,
                     mem_write: id_mem_write,
                     alu_src:   id_alu_src,
                     reg_write: id_reg_write,
                     jump:      id_jump};

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .lu          (lu)
  );

  // Flush lets fetch take the redirect even while stalled
  assign pc_write    = flush | (~hold & ~lu);
  assign if_id_write = pc_write;

  // Only a real, hazard-free ID instruction enters EX; everything else is a zeroed bubble
  assign load_id = ~flush & ~hold & ~lu & id_valid;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
    end else if (flush || !hold) begin
      if (load_id) begin
        ex_valid <= 1'b1;
        ex_ctrl  <= id_ctrl;
        ex_rs1   <= id_rs1;
        ex_rs2   <= id_rs2;
        ex_rd    <= id_rd;
      end else begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_rs1   <= '0;
        ex_rs2   <= '0;
        ex_rd    <= '0;
      end
    end
  end

  assign ex_alu_op    = ex_ctrl.alu_op;
  assign ex_reg_dst   = ex_ctrl.reg_dst;
  assign ex_branch    = ex_ctrl.branch;
  assign ex_mem_read  = ex_ctrl.mem_read;
  assign ex_mem_2_reg = ex_ctrl.mem_2_reg;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_alu_src   = ex_ctrl.alu_src;
  assign ex_reg_write = ex_ctrl.reg_write;
  assign ex_jump      = ex_ctrl.jump;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end else if (!hold && lu) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
